vga_scan_controller: RTL and testbench
======================================

# vga_scan_controller

Frame-level sequencer for the VGA horizontal counter block. Owns that counter's active-low reset, and counts lines from its 10-bit horizontal count. Generates vertical sync, the active-video enable and a frame-start pulse. Runs a per-line prefetch handshake with the sprite line fetcher, so each visible line is requested one line ahead and a late fetch blanks only that line.

## Interface
Parameters: none. Timing is fixed 640x480@60: 800 clocks/line, 525 lines/frame.
- clock  in  1  pixel clock (25.175 MHz); all logic on rising edge
- reset  in  1  synchronous, active-low; reset reset, synchronous, active-low; clock clock
- enable  in  1  level; start scanning / request stop at frame end
- h_count  in  10  horizontal count from the horizontal counter, 0..799, wraps 799->0
- fetch_ack  in  1  fetcher accepts the outstanding line request
- hsync_rst_n  out  1  drives the horizontal counter's reset; low holds it at 0
- vsync  out  1  vertical sync, active low
- video_en  out  1  pixel data valid this cycle
- fetch_req  out  1  line fetch request, held until ack or timeout
- fetch_line  out  9  visible row to fetch, 0..479
- frame_start  out  1  one-cycle pulse at start of each frame
- v_count  out  10  current line, 0..524
- underflow_cnt  out  8  saturating count of missed fetches
- busy  out  1  high while in RUN

## Operation
- States: IDLE, RUN. Reset -> IDLE.
- IDLE:
  - hsync_rst_n=0, v_count=0, vsync=1, video_en=0, fetch_req=0.
  - enable sampled 1 -> RUN next edge. In the same edge: hsync_rst_n<=1, frame_start<=1.
- RUN:
  - busy=1, hsync_rst_n=1.
  - The first RUN cycle sees h_count=0.
- Line counting: h_count==799 sampled -> v_count increments, wrapping 524->0.
- Frame end: h_count==799 on v_count==524.
  - frame_start pulses.
  - If enable==0 at that sample -> IDLE next edge.
  - enable dropping mid-frame has no other effect.
- vsync: 0 while v_count in 0..1; otherwise 1.
- Active region: h_count 144..783 and v_count 35..514.
- Prefetch:
  - Trigger: h_count==784 sampled on line L, where L in 34..513.
  - Action: fetch_req<=1, fetch_line<=L+1-35.
  - The line_valid flag for line L+1 is cleared at the same time.
- Ack: fetch_ack sampled high while fetch_req==1 -> fetch_req<=0, line_valid<=1.
  - fetch_ack while fetch_req==0 is ignored.
- Timeout:
  - Condition: h_count==143 sampled on line L+1 with fetch_req still 1.
  - Action: fetch_req<=0, line_valid stays 0, underflow_cnt increments, saturating at 255.
  - An ack in the same cycle wins: no underflow, line_valid=1.
- video_en = active region AND line_valid.
- underflow_cnt is cleared only by reset.

## Timing
- All outputs are registered. Each output reflects the h_count sampled on the previous edge (1-cycle latency).
- Reset values:
  - hsync_rst_n=0, vsync=1, video_en=0, fetch_req=0, fetch_line=0
  - frame_start=0, v_count=0, underflow_cnt=0, busy=0
- Reset mid-operation:
  - All outputs take their reset values on the next edge.
  - An outstanding fetch_req drops with no ack and is not counted as an underflow.
- fetch_req rises 1 cycle after h_count==784 is sampled.
- fetch_req falls 1 cycle after ack, or 1 cycle after the h_count==143 timeout.
- fetch_line is stable for the whole time fetch_req is high.
- Fetch window: 160 cycles (h 784..799, then 0..143 of the next line).
- Back-to-back frames: frame_start is exactly 420000 cycles apart.
- IDLE->RUN->IDLE: minimum one full frame in RUN.

## Test plan
- Reset, enable=0 for 20 cycles -> hsync_rst_n=0, busy=0, all outputs at reset values. Then enable=1 -> next edge: busy=1, hsync_rst_n=1, frame_start single pulse.
- Run one frame with the counter model and ack always 1 cycle after req:
  - vsync low exactly for v_count 0..1.
  - 480 fetch_req pulses with fetch_line 0..479 in order.
  - video_en high 640 cycles on each of lines 35..514.
  - underflow_cnt=0.
- Withhold ack for fetch_line 100:
  - fetch_req drops after h_count==143 on line 135.
  - video_en=0 for all of line 135.
  - underflow_cnt=1.
  - Line 136 is normal.
- Assert ack in the same cycle as the h_count==143 timeout -> line_valid=1, video_en high on that line, underflow_cnt unchanged.
- Drop enable on line 200 -> scanning continues to h=799/v=524, then IDLE with hsync_rst_n=0. Drop reset while fetch_req=1 -> all outputs at reset values next edge.
- Never ack for 300 lines -> underflow_cnt saturates at 255 and holds.

Source files
------------

// File: rtl/vga_scan_controller.sv
// Frame-level sequencer for 640x480@60 VGA scanning.
// Releases the horizontal counter, counts lines from its count, produces
// vsync, video enable and frame-start, and runs a one-line-ahead prefetch
// handshake with the sprite line fetcher. A late fetch blanks only its line.
module vga_scan_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] h_count,
  input  logic       fetch_ack,
  output logic       hsync_rst_n,
  output logic       vsync,
  output logic       video_en,
  output logic       fetch_req,
  output logic [8:0] fetch_line,
  output logic       frame_start,
  output logic [9:0] v_count,
  output logic [7:0] underflow_cnt,
  output logic       busy
);

  localparam logic [9:0] H_LAST      = 10'd799;
  localparam logic [9:0] H_ACT_FIRST = 10'd144;
  localparam logic [9:0] H_ACT_LAST  = 10'd783;
  localparam logic [9:0] H_PREFETCH  = 10'd784;
  localparam logic [9:0] H_DEADLINE  = 10'd143;
  localparam logic [9:0] V_LAST      = 10'd524;
  localparam logic [9:0] V_ACT_FIRST = 10'd35;
  localparam logic [9:0] V_ACT_LAST  = 10'd514;
  localparam logic [9:0] V_PRE_FIRST = 10'd34;
  localparam logic [9:0] V_PRE_LAST  = 10'd513;

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state_q, state_d;
  logic       hsyncRstN_q, hsyncRstN_d;
  logic       vsync_q, vsync_d;
  logic       videoEn_q, videoEn_d;
  logic       fetchReq_q, fetchReq_d;
  logic [8:0] fetchLine_q, fetchLine_d;
  logic       frameStart_q, frameStart_d;
  logic [9:0] vCount_q, vCount_d;
  logic [7:0] underflow_q, underflow_d;
  logic       busy_q, busy_d;
  logic       lineValid_q, lineValid_d;

  logic lineEnd, frameEnd, hActive, vActive, prefetchHit;

  assign lineEnd     = (h_count == H_LAST);
  assign frameEnd    = lineEnd && (vCount_q == V_LAST);
  assign hActive     = (h_count >= H_ACT_FIRST) && (h_count <= H_ACT_LAST);
  assign vActive     = (vCount_q >= V_ACT_FIRST) && (vCount_q <= V_ACT_LAST);
  assign prefetchHit = (h_count == H_PREFETCH) &&
                       (vCount_q >= V_PRE_FIRST) && (vCount_q <= V_PRE_LAST);

  assign hsync_rst_n   = hsyncRstN_q;
  assign vsync         = vsync_q;
  assign video_en      = videoEn_q;
  assign fetch_req     = fetchReq_q;
  assign fetch_line    = fetchLine_q;
  assign frame_start   = frameStart_q;
  assign v_count       = vCount_q;
  assign underflow_cnt = underflow_q;
  assign busy          = busy_q;

  // State and output registers; every output is registered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      hsyncRstN_q  <= 1'b0;
      vsync_q      <= 1'b1;
      videoEn_q    <= 1'b0;
      fetchReq_q   <= 1'b0;
      fetchLine_q  <= 9'd0;
      frameStart_q <= 1'b0;
      vCount_q     <= 10'd0;
      underflow_q  <= 8'd0;
      busy_q       <= 1'b0;
      lineValid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hsyncRstN_q  <= hsyncRstN_d;
      vsync_q      <= vsync_d;
      videoEn_q    <= videoEn_d;
      fetchReq_q   <= fetchReq_d;
      fetchLine_q  <= fetchLine_d;
      frameStart_q <= frameStart_d;
      vCount_q     <= vCount_d;
      underflow_q  <= underflow_d;
      busy_q       <= busy_d;
      lineValid_q  <= lineValid_d;
    end
  end

  // Next-state: line/frame counting, prefetch handshake and stop at frame end.
  always_comb begin
    state_d      = state_q;
    hsyncRstN_d  = hsyncRstN_q;
    videoEn_d    = 1'b0;
    fetchReq_d   = fetchReq_q;
    fetchLine_d  = fetchLine_q;
    frameStart_d = 1'b0;
    vCount_d     = vCount_q;
    underflow_d  = underflow_q;
    busy_d       = busy_q;
    lineValid_d  = lineValid_q;

    case (state_q)
      IDLE: begin
        hsyncRstN_d = 1'b0;
        busy_d      = 1'b0;
        vCount_d    = 10'd0;
        fetchReq_d  = 1'b0;
        lineValid_d = 1'b0;
        if (enable) begin
          state_d      = RUN;
          hsyncRstN_d  = 1'b1;
          busy_d       = 1'b1;
          frameStart_d = 1'b1;
        end
      end
      RUN: begin
        hsyncRstN_d = 1'b1;
        busy_d      = 1'b1;
        videoEn_d   = hActive && vActive && lineValid_q;
        if (lineEnd) begin
          vCount_d = frameEnd ? 10'd0 : vCount_q + 10'd1;
        end
        if (fetchReq_q && fetch_ack) begin
          fetchReq_d  = 1'b0;
          lineValid_d = 1'b1;
        end else if (fetchReq_q && (h_count == H_DEADLINE)) begin
          fetchReq_d = 1'b0;
          if (underflow_q != 8'hFF) begin
            underflow_d = underflow_q + 8'd1;
          end
        end
        if (prefetchHit) begin
          fetchReq_d  = 1'b1;
          fetchLine_d = 9'(vCount_q - V_PRE_FIRST);
          lineValid_d = 1'b0;
        end
        if (frameEnd) begin
          frameStart_d = 1'b1;
          if (!enable) begin
            state_d     = IDLE;
            hsyncRstN_d = 1'b0;
            busy_d      = 1'b0;
            fetchReq_d  = 1'b0;
            lineValid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    vsync_d = (state_d == RUN) ? (vCount_d > 10'd1) : 1'b1;
  end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench for vga_scan_controller with a horizontal counter model.
// Most lines are run compressed (h skips stretches with no events) to keep
// frames short; selected lines run at full 800-clock length.
module tb_vga_scan_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       fetch_ack;
  logic [9:0] hCount = 10'd0;
  logic       hsync_rst_n, vsync, video_en, fetch_req, frame_start, busy;
  logic [8:0] fetch_line;
  logic [9:0] v_count;
  logic [7:0] underflow_cnt;

  int checks = 0;
  int errors = 0;

  int         fullLo = -1;
  int         fullHi = -1;
  logic [8:0] withholdLine = 9'h1FF;
  logic [8:0] lateLine = 9'h1FF;
  logic       ackNever = 1'b0;
  logic       fastLine;

  int         videoCnt[525];
  int         reqLen[480];
  int         vsyncLowCnt, vsyncBadCnt, reqPulses, orderErr, unstableCnt;
  logic [8:0] expLine, curLine;
  logic       prevReq = 1'b0;
  int         cyc = 0;
  int         reqStart = 0;
  int         lastFs = 0;
  int         framePeriod = 0;

  vga_scan_controller dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .h_count      (hCount),
    .fetch_ack    (fetch_ack),
    .hsync_rst_n  (hsync_rst_n),
    .vsync        (vsync),
    .video_en     (video_en),
    .fetch_req    (fetch_req),
    .fetch_line   (fetch_line),
    .frame_start  (frame_start),
    .v_count      (v_count),
    .underflow_cnt(underflow_cnt),
    .busy         (busy)
  );

  // Pixel clock
  always #20 clock = ~clock;

  assign fastLine = !((int'(v_count) >= fullLo) && (int'(v_count) <= fullHi));

  // Horizontal counter: held at 0 by hsync_rst_n, compressed on fast lines
  always @(posedge clock) begin
    if (!hsync_rst_n) hCount <= 10'd0;
    else if (hCount == 10'd799) hCount <= 10'd0;
    else if (fastLine && hCount == 10'd1) hCount <= 10'd140;
    else if (fastLine && hCount == 10'd146) hCount <= 10'd780;
    else if (fastLine && hCount == 10'd787) hCount <= 10'd796;
    else hCount <= hCount + 10'd1;
  end

  // Fetcher model: acks one cycle after request, with per-line exceptions
  initial begin
    fetch_ack = 1'b0;
    forever begin
      @(negedge clock);
      if (ackNever || !fetch_req) fetch_ack = 1'b0;
      else if (fetch_line == lateLine) fetch_ack = (hCount == 10'd143);
      else fetch_ack = (fetch_line != withholdLine);
    end
  end

  // Output monitor gathering per-frame statistics
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (video_en && v_count < 10'd525) videoCnt[v_count]++;
      if (!vsync) begin
        vsyncLowCnt++;
        if (v_count > 10'd1) vsyncBadCnt++;
      end
      if (fetch_req && !prevReq) begin
        reqPulses++;
        if (fetch_line != expLine) orderErr++;
        expLine  = expLine + 9'd1;
        curLine  = fetch_line;
        reqStart = cyc;
      end else if (fetch_req && fetch_line != curLine) begin
        unstableCnt++;
      end
      if (!fetch_req && prevReq && curLine < 9'd480) reqLen[curLine] = cyc - reqStart;
      prevReq = fetch_req;
      if (frame_start) begin
        framePeriod = cyc - lastFs;
        lastFs = cyc;
      end
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic en);
    reset  = rstN;
    enable = en;
  endtask

  task automatic clearStats();
    for (int i = 0; i < 525; i++) videoCnt[i] = 0;
    for (int i = 0; i < 480; i++) reqLen[i] = 0;
    vsyncLowCnt = 0;
    vsyncBadCnt = 0;
    reqPulses   = 0;
    orderErr    = 0;
    unstableCnt = 0;
    expLine     = 9'd0;
  endtask

  task automatic checkIdleOutputs(input string pfx);
    checkOutput({pfx, "_hsync_rst_n"}, hsync_rst_n, 0);
    checkOutput({pfx, "_vsync"}, vsync, 1);
    checkOutput({pfx, "_video_en"}, video_en, 0);
    checkOutput({pfx, "_fetch_req"}, fetch_req, 0);
    checkOutput({pfx, "_fetch_line"}, fetch_line, 0);
    checkOutput({pfx, "_frame_start"}, frame_start, 0);
    checkOutput({pfx, "_v_count"}, v_count, 0);
    checkOutput({pfx, "_underflow"}, underflow_cnt, 0);
    checkOutput({pfx, "_busy"}, busy, 0);
  endtask

  // Expected video_en cycles per line: 7 on compressed lines, 640 on full ones
  function automatic int expVideo(input int v, input bit frame2);
    if (v < 35 || v > 514) return 0;
    if (frame2 && v == 135) return 0;
    if (frame2 && v >= 134 && v <= 136) return 640;
    return 7;
  endfunction

  function automatic int badVideoLines(input bit frame2);
    int bad = 0;
    for (int v = 0; v < 525; v++) if (videoCnt[v] != expVideo(v, frame2)) bad++;
    return bad;
  endfunction

  // Directed test sequence
  initial begin
    int n;
    int total;
    clearStats();
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clock);
    applyStimulus(1'b1, 1'b0);
    repeat (20) @(negedge clock);
    checkIdleOutputs("reset");

    @(posedge clock);
    clearStats();
    @(negedge clock);
    applyStimulus(1'b1, 1'b1);
    @(negedge clock);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_hsync_rst_n", hsync_rst_n, 1);
    checkOutput("start_frame_start", frame_start, 1);
    checkOutput("start_v_count", v_count, 0);
    @(negedge clock);
    checkOutput("start_pulse_single", frame_start, 0);

    // Frame 1: all compressed lines, prompt acks
    repeat (11024) @(posedge clock);
    checkOutput("f1_vsync_low_cycles", vsyncLowCnt, 42);
    checkOutput("f1_vsync_low_outside", vsyncBadCnt, 0);
    checkOutput("f1_req_pulses", reqPulses, 480);
    checkOutput("f1_req_order", orderErr, 0);
    checkOutput("f1_req_unstable", unstableCnt, 0);
    checkOutput("f1_req_len_line0", reqLen[0], 1);
    checkOutput("f1_req_len_line479", reqLen[479], 1);
    checkOutput("f1_bad_video_lines", badVideoLines(1'b0), 0);
    checkOutput("f1_underflow", underflow_cnt, 0);
    withholdLine = 9'd100;
    lateLine     = 9'd200;
    fullLo       = 134;
    fullHi       = 136;
    clearStats();
    @(negedge clock);
    checkOutput("f1_end_frame_start", frame_start, 1);
    @(posedge clock);
    checkOutput("f1_period", framePeriod, 11025);

    // Frame 2: withheld ack on row 100, ack at the deadline on row 200
    repeat (13361) @(posedge clock);
    checkOutput("f2_req_pulses", reqPulses, 480);
    checkOutput("f2_req_order", orderErr, 0);
    checkOutput("f2_req_unstable", unstableCnt, 0);
    checkOutput("f2_req_len_withheld", reqLen[100], 159);
    checkOutput("f2_req_len_late", reqLen[200], 13);
    checkOutput("f2_video_line134", videoCnt[134], 640);
    checkOutput("f2_video_line135", videoCnt[135], 0);
    checkOutput("f2_video_line136", videoCnt[136], 640);
    checkOutput("f2_video_line235", videoCnt[235], 7);
    checkOutput("f2_bad_video_lines", badVideoLines(1'b1), 0);
    checkOutput("f2_underflow", underflow_cnt, 1);
    fullLo       = -1;
    fullHi       = -1;
    withholdLine = 9'h1FF;
    lateLine     = 9'h1FF;
    @(negedge clock);
    checkOutput("f2_end_frame_start", frame_start, 1);
    @(posedge clock);
    checkOutput("f2_period", framePeriod, 13362);

    // Frame 3: drop enable on line 200, expect stop at frame end
    n = 0;
    while (v_count != 10'd200 && n < 10000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("wait_line200", v_count, 200);
    applyStimulus(1'b1, 1'b0);
    n = 0;
    while (busy && n < 20000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("stop_latency", n, 6825);
    checkOutput("stop_hsync_rst_n", hsync_rst_n, 0);
    checkOutput("stop_v_count", v_count, 0);
    checkOutput("stop_vsync", vsync, 1);
    checkOutput("stop_frame_start", frame_start, 1);
    checkOutput("stop_fetch_req", fetch_req, 0);
    repeat (5) @(negedge clock);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_hsync_rst_n", hsync_rst_n, 0);
    checkOutput("idle_frame_start", frame_start, 0);

    // Reset while a fetch request is outstanding
    applyStimulus(1'b1, 1'b1);
    n = 0;
    while (!fetch_req && n < 3000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("wait_req", fetch_req, 1);
    checkOutput("underflow_kept", underflow_cnt, 1);
    applyStimulus(1'b0, 1'b0);
    @(negedge clock);
    checkIdleOutputs("midreset");
    applyStimulus(1'b1, 1'b0);

    // Never acknowledge: underflow count saturates
    @(posedge clock);
    ackNever = 1'b1;
    clearStats();
    @(negedge clock);
    applyStimulus(1'b1, 1'b1);
    n = 0;
    while (underflow_cnt != 8'd255 && n < 15000) begin
      @(negedge clock);
      n++;
    end
    checkOutput("sat_reach", underflow_cnt, 255);
    checkOutput("sat_line", v_count, 289);
    @(posedge clock);
    clearStats();
    repeat (300 * 21) @(posedge clock);
    checkOutput("sat_hold", underflow_cnt, 255);
    total = 0;
    for (int v = 0; v < 525; v++) total += videoCnt[v];
    checkOutput("never_ack_no_video", total, 0);
    checkOutput("never_ack_reqs_seen", int'(reqPulses > 0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
